// File: rtl/pong_pkg.sv
// Shared pong types: match-sequencer state encoding, score width and
// serve-direction constants.
package pong_pkg;

  localparam int SCORE_W = 4;

  localparam logic SERVE_TO_P1 = 1'b0;
  localparam logic SERVE_TO_P2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RALLY      = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } match_state_e;

endpackage

// File: rtl/match_ctrl_if.sv
// Match-control bundle between ball/collision logic (master) and the point/serve
// sequencer (slave); also carries the score outputs to the display path.
interface match_ctrl_if;
  import pong_pkg::*;

  logic                 start;
  logic                 frame_tick;
  logic                 miss1;
  logic                 miss2;
  logic                 ball_launch;
  logic                 serve_dir;
  logic                 ball_freeze;
  logic                 point_flash;
  logic [SCORE_W-1:0]   score_p1;
  logic [SCORE_W-1:0]   score_p2;
  logic [2*SCORE_W-1:0] scoreboard;
  logic                 game_over;
  logic                 winner;

  modport master (
    output start, frame_tick, miss1, miss2,
    input  ball_launch, serve_dir, ball_freeze, point_flash,
    input  score_p1, score_p2, scoreboard, game_over, winner
  );

  modport slave (
    input  start, frame_tick, miss1, miss2,
    output ball_launch, serve_dir, ball_freeze, point_flash,
    output score_p1, score_p2, scoreboard, game_over, winner
  );

endinterface

// File: rtl/match_ctrl.sv
// Point/serve sequencer for a two-player pong match: scores, serve/point timing,
// ball launch and winner. Define MATCH_CTRL_DEUCE_EN for win-by-two (deuce) rules.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_HOLD  = 30,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         resetn,
  match_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]   SERVE_LAST  = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(POINT_HOLD - 1);
  localparam logic [SCORE_W:0]   WIN_EXT     = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] DEUCE_SCORE = SCORE_W'(WIN_SCORE - 1);

  match_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               launch_q, launch_d;
  logic               freeze_q, freeze_d;
  logic               flash_q, flash_d;
  logic               over_q, over_d;

  // Scores are widened by one bit so the lead comparison cannot wrap.
  function automatic logic has_won(input logic [SCORE_W-1:0] own,
                                   input logic [SCORE_W-1:0] other);
    logic [SCORE_W:0] own_e;
    logic [SCORE_W:0] other_e;
    own_e   = {1'b0, own};
    other_e = {1'b0, other};
`ifdef MATCH_CTRL_DEUCE_EN
    return (own_e >= WIN_EXT) && (own_e >= other_e + (SCORE_W+1)'(2));
`else
    return (own_e >= WIN_EXT) && (other_e == other_e);
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    launch_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          state_d     = ST_SERVE_WAIT;
          cnt_d       = '0;
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = SERVE_TO_P1;
        end
      end

      ST_SERVE_WAIT: begin
        if (bus.frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            launch_d = 1'b1;
            state_d  = ST_RALLY;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RALLY: begin
        if (bus.miss1 && bus.miss2) begin
          // Simultaneous misses are a let: replay the serve, nobody scores.
          state_d = ST_SERVE_WAIT;
          cnt_d   = '0;
        end else if (bus.miss1) begin
          score2_d    = score2_q + SCORE_W'(1);
          serve_dir_d = SERVE_TO_P1;
          state_d     = ST_POINT;
          cnt_d       = '0;
        end else if (bus.miss2) begin
          score1_d    = score1_q + SCORE_W'(1);
          serve_dir_d = SERVE_TO_P2;
          state_d     = ST_POINT;
          cnt_d       = '0;
        end
`ifdef MATCH_CTRL_DEUCE_EN
        if ((bus.miss1 != bus.miss2) && (score1_d == score2_d) &&
            ({1'b0, score1_d} >= WIN_EXT)) begin
          score1_d = DEUCE_SCORE;
          score2_d = DEUCE_SCORE;
        end
`endif
      end

      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (has_won(score1_q, score2_q)) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b0;
            end else if (has_won(score2_q, score1_q)) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = ST_SERVE_WAIT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    freeze_d = (state_d != ST_RALLY);
    flash_d  = (state_d == ST_POINT);
    over_d   = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_dir_q <= SERVE_TO_P1;
      winner_q    <= 1'b0;
      launch_q    <= 1'b0;
      freeze_q    <= 1'b1;
      flash_q     <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      launch_q    <= launch_d;
      freeze_q    <= freeze_d;
      flash_q     <= flash_d;
      over_q      <= over_d;
    end
  end

  assign bus.ball_launch = launch_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.ball_freeze = freeze_q;
  assign bus.point_flash = flash_q;
  assign bus.score_p1    = score1_q;
  assign bus.score_p2    = score2_q;
  assign bus.scoreboard  = {score2_q, score1_q};
  assign bus.game_over   = over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed scoreboard bench for match_ctrl; follows MATCH_CTRL_DEUCE_EN when defined.
module tb_match_ctrl;
  import pong_pkg::*;

  localparam int WIN = 7;
  localparam int SD  = 60;
  localparam int PH  = 30;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  match_ctrl_if bus ();

  match_ctrl #(
    .WIN_SCORE  (WIN),
    .SERVE_DELAY(SD),
    .POINT_HOLD (PH),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] sb;
    logic       dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m1 = 0;
  int   m2 = 0;
  bit   mdir = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic with_start);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.start      = with_start;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
  endtask

  // Serve: launch must appear exactly on the SD-th tick.
  task automatic serve(input string tag, input bit stop_at_launch);
    int early;
    early = 0;
    for (int i = 1; i < SD; i++) begin
      tick(1'b0);
      if (bus.ball_launch !== 1'b0 || bus.ball_freeze !== 1'b1) early++;
    end
    chk({tag, "_early_launch"}, early, 0);
    tick(1'b0);
    chk({tag, "_launch"}, bus.ball_launch, 1);
    chk({tag, "_freeze_drop"}, bus.ball_freeze, 0);
    if (!stop_at_launch) begin
      @(negedge clk);
      chk({tag, "_launch_pulse"}, bus.ball_launch, 0);
    end
  endtask

  task automatic model(input bit p1s, output bit over, output bit win);
    if (p1s) m1++; else m2++;
    mdir = p1s;
`ifdef MATCH_CTRL_DEUCE_EN
    if (m1 == m2 && m1 >= WIN) begin
      m1 = WIN - 1;
      m2 = WIN - 1;
    end
    over = (m1 >= WIN && m1 >= m2 + 2) || (m2 >= WIN && m2 >= m1 + 2);
`else
    over = (m1 >= WIN) || (m2 >= WIN);
`endif
    win = (m2 > m1);
  endtask

  task automatic point(input string tag, input bit p1s, input bit tick_on_entry,
                       input bit start_in_hold);
    exp_t e;
    bit   over;
    bit   win;
    int   early;
    serve(tag, 1'b0);
    model(p1s, over, win);
    @(negedge clk);
    bus.miss1      = !p1s;
    bus.miss2      = p1s;
    bus.frame_tick = tick_on_entry;
    e.sb  = {4'(m2), 4'(m1)};
    e.dir = mdir;
    exp_q.push_back(e);
    @(negedge clk);
    bus.miss1      = 1'b0;
    bus.miss2      = 1'b0;
    bus.frame_tick = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_scoreboard"}, bus.scoreboard, e.sb);
    chk({tag, "_score_p1"}, bus.score_p1, e.sb[3:0]);
    chk({tag, "_serve_dir"}, bus.serve_dir, e.dir);
    chk({tag, "_flash_on"}, bus.point_flash, 1);
    chk({tag, "_freeze_on"}, bus.ball_freeze, 1);
    early = 0;
    for (int i = 1; i < PH; i++) begin
      tick(start_in_hold && (i == 1));
      if (bus.point_flash !== 1'b1) early++;
    end
    chk({tag, "_flash_held"}, early, 0);
    tick(1'b0);
    chk({tag, "_flash_off"}, bus.point_flash, 0);
    chk({tag, "_game_over"}, bus.game_over, over);
    if (over) chk({tag, "_winner"}, bus.winner, win);
  endtask

  initial begin
    exp_t e;
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.miss1      = 1'b0;
    bus.miss2      = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_freeze", bus.ball_freeze, 1);
    chk("rst_launch", bus.ball_launch, 0);
    chk("rst_flash", bus.point_flash, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_scoreboard", bus.scoreboard, 0);
    chk("rst_serve_dir", bus.serve_dir, 0);
    chk("rst_winner", bus.winner, 0);

    resetn = 1'b1;
    repeat (3) tick(1'b0);
    chk("idle_no_launch", bus.ball_launch, 0);
    chk("idle_freeze", bus.ball_freeze, 1);

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_scores", bus.scoreboard, 0);
    chk("start_freeze", bus.ball_freeze, 1);

    // Entry-cycle tick and a start pulse inside the hold must both be ignored.
    point("p1_first", 1'b1, 1'b1, 1'b1);

    serve("let", 1'b0);
    @(negedge clk);
    bus.miss1 = 1'b1;
    bus.miss2 = 1'b1;
    e.sb  = {4'(m2), 4'(m1)};
    e.dir = mdir;
    exp_q.push_back(e);
    @(negedge clk);
    bus.miss1 = 1'b0;
    bus.miss2 = 1'b0;
    e = exp_q.pop_front();
    chk("let_scoreboard", bus.scoreboard, e.sb);
    chk("let_serve_dir", bus.serve_dir, e.dir);
    chk("let_no_flash", bus.point_flash, 0);
    chk("let_freeze", bus.ball_freeze, 1);

    point("p2_first", 1'b0, 1'b0, 1'b0);

`ifdef MATCH_CTRL_DEUCE_EN
    repeat (5) point("p1_run", 1'b1, 1'b0, 1'b0);
    repeat (5) point("p2_run", 1'b0, 1'b0, 1'b0);
    chk("deuce_66", bus.scoreboard, 8'h66);
    point("deuce_p2", 1'b0, 1'b0, 1'b0);
    chk("deuce_67", bus.scoreboard, 8'h76);
    point("deuce_level", 1'b1, 1'b0, 1'b0);
    chk("deuce_back_66", bus.scoreboard, 8'h66);
    point("deuce_adv", 1'b1, 1'b0, 1'b0);
    point("deuce_win", 1'b1, 1'b0, 1'b0);
    chk("deuce_final", bus.scoreboard, 8'h68);
`else
    repeat (6) point("p1_run", 1'b1, 1'b0, 1'b0);
    chk("final_score", bus.scoreboard, 8'h17);
`endif
    chk("over_flag", bus.game_over, 1);
    chk("over_winner_p1", bus.winner, 0);
    repeat (3) tick(1'b0);
    chk("over_scores_held", bus.score_p1, 4'(m1));

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m1 = 0;
    m2 = 0;
    mdir = 1'b0;
    chk("restart_scores", bus.scoreboard, 0);
    chk("restart_game_over", bus.game_over, 0);
    chk("restart_serve_dir", bus.serve_dir, 0);

    point("r_a", 1'b1, 1'b0, 1'b0);
    point("r_b", 1'b0, 1'b0, 1'b0);
    point("r_c", 1'b1, 1'b0, 1'b0);
    point("r_d", 1'b0, 1'b0, 1'b0);
    point("r_e", 1'b1, 1'b0, 1'b0);
    chk("pre_reset_32", bus.scoreboard, 8'h23);

    // Async reset lands while the launch pulse is still high.
    serve("rst_serve", 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_launch_killed", bus.ball_launch, 0);
    chk("async_scores", bus.scoreboard, 0);
    chk("async_freeze", bus.ball_freeze, 1);
    chk("async_flash", bus.point_flash, 0);
    chk("async_game_over", bus.game_over, 0);
    chk("async_serve_dir", bus.serve_dir, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (SD + 2) tick(1'b0);
    chk("post_rst_idle_launch", bus.ball_launch, 0);
    chk("post_rst_idle_freeze", bus.ball_freeze, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
